// File: rtl/forwarding_if.sv
// Hazard-unit bus: operand source addresses/read strobes and the destination
// addresses/write strobes of the three downstream stages. It also carries the
// bypass-mux selects and the freeze request back to the pipeline.
//   master : pipeline side (drives addresses/strobes, receives selects/freeze)
//   slave  : forwarding unit side
// Parameter AW : register-address width.
interface forwarding_if #(
    parameter int AW = 4
);
    logic [AW-1:0] in_add1, in_add2, in_add3, in_add4;
    logic          rd1, rd2, rd3, rd4;
    logic [AW-1:0] match_add1, match_add2, match_add3;
    logic          wr1, wr2, wr3;
    logic          load;
    logic [1:0]    mux_sel1, mux_sel2, mux_sel3, mux_sel4;
    logic          freeze;

    modport master (
        output in_add1, in_add2, in_add3, in_add4,
        output rd1, rd2, rd3, rd4,
        output match_add1, match_add2, match_add3,
        output wr1, wr2, wr3, load,
        input  mux_sel1, mux_sel2, mux_sel3, mux_sel4, freeze
    );

    modport slave (
        input  in_add1, in_add2, in_add3, in_add4,
        input  rd1, rd2, rd3, rd4,
        input  match_add1, match_add2, match_add3,
        input  wr1, wr2, wr3, load,
        output mux_sel1, mux_sel2, mux_sel3, mux_sel4, freeze
    );
endinterface

// File: rtl/forwarding_logic.sv
// Data-hazard unit beside the ID/EX boundary. Each of four operand source
// addresses is compared against the destinations of stage 1 (EX), 2 (MEM) and
// 3 (WB). The result is a per-operand bypass select (00 regfile, 01 stage1,
// 10 stage2, 11 stage3, nearest stage wins) and a load-use freeze request.
// Selects and freeze are purely combinational. A saturating freeze counter is
// kept for debug.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   fwd         : forwarding_if.slave (addresses, strobes, selects, freeze)
//   freeze_cnt  : cycles with freeze=1 since reset, saturating
//   fwd_cnt     : (only with FWD_PERF_EN) cycles with any non-regfile select,
//                 saturating
// Optional feature macro: FWD_PERF_EN
module forwarding_logic #(
    parameter int AW      = 4,
    parameter int CNT_W   = 16,
    parameter int PC_ADDR = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    forwarding_if.slave      fwd,
`ifdef FWD_PERF_EN
    output logic [CNT_W-1:0] fwd_cnt,
`endif
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam logic [AW-1:0] PC_A = AW'(PC_ADDR);

    logic [AW-1:0] src [4];
    logic [AW-1:0] dst [3];
    logic [3:0]    rd;
    logic [2:0]    wr;
    logic [1:0]    sel [4];
    logic [3:0]    hit1;
    logic          freeze_c;
    logic          any_fwd;

    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    always_comb begin
        src[0] = fwd.in_add1;
        src[1] = fwd.in_add2;
        src[2] = fwd.in_add3;
        src[3] = fwd.in_add4;
        dst[0] = fwd.match_add1;
        dst[1] = fwd.match_add2;
        dst[2] = fwd.match_add3;
        rd     = {fwd.rd4, fwd.rd3, fwd.rd2, fwd.rd1};
        wr     = {fwd.wr3, fwd.wr2, fwd.wr1};
        hit1   = '0;
        for (int n = 0; n < 4; n++) begin
            sel[n] = 2'b00;
            // Reset gates every select; PC reads never bypass.
            if (rst_n && rd[n] && (src[n] != PC_A)) begin
                if (wr[0] && (src[n] == dst[0])) begin
                    sel[n]  = 2'b01;
                    hit1[n] = 1'b1;
                end else if (wr[1] && (src[n] == dst[1])) begin
                    sel[n] = 2'b10;
                end else if (wr[2] && (src[n] == dst[2])) begin
                    sel[n] = 2'b11;
                end
            end
        end
        // A stage-1 load result is not available yet, so any consumer must wait.
        freeze_c = rst_n && fwd.load && (|hit1);
        any_fwd  = (sel[0] != 2'b00) || (sel[1] != 2'b00) ||
                   (sel[2] != 2'b00) || (sel[3] != 2'b00);
    end

    assign fwd.mux_sel1 = sel[0];
    assign fwd.mux_sel2 = sel[1];
    assign fwd.mux_sel3 = sel[2];
    assign fwd.mux_sel4 = sel[3];
    assign fwd.freeze   = freeze_c;

    always_comb begin
        freeze_cnt_d = freeze_cnt_q;
        if (freeze_c && (freeze_cnt_q != '1)) begin
            freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze_cnt_q <= '0;
        end else begin
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign freeze_cnt = freeze_cnt_q;

`ifdef FWD_PERF_EN
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        fwd_cnt_d = fwd_cnt_q;
        if (any_fwd && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_q <= '0;
        end else begin
            fwd_cnt_q <= fwd_cnt_d;
        end
    end

    assign fwd_cnt = fwd_cnt_q;
`else
    logic unused_any_fwd;
    assign unused_any_fwd = any_fwd;
`endif

endmodule

// File: tb/tb_forwarding_logic.sv
// Directed bench for forwarding_logic. A narrow counter (CNT_W=4) lets the
// saturation behaviour be reached in a few cycles.
module tb_forwarding_logic;

    localparam int AW    = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [CNT_W-1:0] freeze_cnt;
`ifdef FWD_PERF_EN
    logic [CNT_W-1:0] fwd_cnt;
`endif

    int tests = 0;
    int fails = 0;

    forwarding_if #(.AW(AW)) ifc ();

    forwarding_logic #(.AW(AW), .CNT_W(CNT_W), .PC_ADDR(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fwd        (ifc),
`ifdef FWD_PERF_EN
        .fwd_cnt    (fwd_cnt),
`endif
        .freeze_cnt (freeze_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [3:0] r);
        ifc.rd1 = r[0];
        ifc.rd2 = r[1];
        ifc.rd3 = r[2];
        ifc.rd4 = r[3];
    endtask

    task automatic set_wr(input logic [2:0] w);
        ifc.wr1 = w[0];
        ifc.wr2 = w[1];
        ifc.wr3 = w[2];
    endtask

    initial begin
        rst_n          = 1'b0;
        ifc.in_add1    = 4'd5;
        ifc.in_add2    = 4'd8;
        ifc.in_add3    = 4'd10;
        ifc.in_add4    = 4'd7;
        ifc.match_add1 = 4'd10;
        ifc.match_add2 = 4'd9;
        ifc.match_add3 = 4'd5;
        set_rd(4'b0000);
        set_wr(3'b000);
        ifc.load = 1'b0;
        #2;
        check("rst_cnt", 16'(freeze_cnt), 16'h0);
        check("rst_freeze", 16'(ifc.freeze), 16'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // T1: nothing read or written
        check("t1_sel1", 16'(ifc.mux_sel1), 16'h0);
        check("t1_sel3", 16'(ifc.mux_sel3), 16'h0);
        check("t1_freeze", 16'(ifc.freeze), 16'h0);

        // T2: operands 1,2 read, all stages write
        set_rd(4'b0011);
        set_wr(3'b111);
        #1;
        check("t2_sel1", 16'(ifc.mux_sel1), 16'h3);
        check("t2_sel2", 16'(ifc.mux_sel2), 16'h0);
        check("t2_freeze", 16'(ifc.freeze), 16'h0);

        // T3: operands 3,4 read; 10 hits stage 1, and operand 1 is gated off
        set_rd(4'b1100);
        #1;
        check("t3_sel3", 16'(ifc.mux_sel3), 16'h1);
        check("t3_sel4", 16'(ifc.mux_sel4), 16'h0);
        check("t3_sel1_rd0", 16'(ifc.mux_sel1), 16'h0);
        check("t3_freeze", 16'(ifc.freeze), 16'h0);

        // T4: load without stage-1 consumer
        set_rd(4'b1011);
        ifc.load = 1'b1;
        #1;
        check("t4_freeze", 16'(ifc.freeze), 16'h0);
        check("t4_sel1", 16'(ifc.mux_sel1), 16'h3);
        @(negedge clk);
        check("t4_cnt", 16'(freeze_cnt), 16'h0);

        // T5: load-use hazard on operand 3
        set_rd(4'b0101);
        #1;
        check("t5_freeze", 16'(ifc.freeze), 16'h1);
        check("t5_sel3", 16'(ifc.mux_sel3), 16'h1);
        check("t5_sel1", 16'(ifc.mux_sel1), 16'h3);
        @(negedge clk);
        repeat (2) @(negedge clk);
        check("t5_cnt3", 16'(freeze_cnt), 16'h3);
        set_wr(3'b011);
        set_rd(4'b0001);
        ifc.load = 1'b0;
        #1;
        check("t5_sel1_nowr3", 16'(ifc.mux_sel1), 16'h0);
        check("t5_freeze_off", 16'(ifc.freeze), 16'h0);
        repeat (2) @(negedge clk);
        check("t5_cnt_hold", 16'(freeze_cnt), 16'h3);

        // Saturation: 20 more freeze cycles on a 4-bit counter
        set_wr(3'b111);
        set_rd(4'b0101);
        ifc.load = 1'b1;
        repeat (20) @(negedge clk);
        check("sat_cnt", 16'(freeze_cnt), 16'hF);

        // Reset mid-stall
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_cnt", 16'(freeze_cnt), 16'h0);
        check("midrst_freeze", 16'(ifc.freeze), 16'h0);
        check("midrst_sel3", 16'(ifc.mux_sel3), 16'h0);
        check("midrst_sel1", 16'(ifc.mux_sel1), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_freeze", 16'(ifc.freeze), 16'h1);
        check("postrst_sel3", 16'(ifc.mux_sel3), 16'h1);
        @(negedge clk);
        check("postrst_cnt1", 16'(freeze_cnt), 16'h1);

        // T6: stage 1 and stage 3 both write 5 -> nearest wins
        ifc.load       = 1'b0;
        ifc.match_add1 = 4'd5;
        set_rd(4'b0001);
        #1;
        check("t6_prio", 16'(ifc.mux_sel1), 16'h1);
        // Stage 2 and 3 both write 5 -> stage 2 wins
        ifc.wr1        = 1'b0;
        ifc.match_add2 = 4'd5;
        #1;
        check("t6_prio2", 16'(ifc.mux_sel1), 16'h2);
        // PC address is never forwarded even with a full match
        ifc.wr1        = 1'b1;
        ifc.in_add1    = 4'd15;
        ifc.match_add1 = 4'd15;
        #1;
        check("t6_pc", 16'(ifc.mux_sel1), 16'h0);
        // Reset gating of an otherwise-forwarding select
        ifc.in_add1 = 4'd5;
        ifc.match_add1 = 4'd5;
        #1;
        check("t6_pre_rst", 16'(ifc.mux_sel1), 16'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sel1", 16'(ifc.mux_sel1), 16'h0);
        check("t6_rst_cnt", 16'(freeze_cnt), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
